// File: rtl/cam_tag_ctrl.sv
// rtl/cam_tag_ctrl.sv - sequencing controller for a small tag CAM (lookup, allocate, invalidate, flush)
module cam_tag_ctrl #(
    parameter int TAG_W   = 8,
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [1:0]         op,
    input  logic [TAG_W-1:0]   tag,
    output logic               busy,
    output logic               ack,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               allocated,
    output logic [IDX_W-1:0]   alloc_idx,
    output logic [ENTRIES-1:0] valid,
    output logic               cam_we_n,
    output logic               cam_rd_n,
    output logic [TAG_W-1:0]   cam_din,
    output logic [TAG_W-1:0]   cam_argin,
    output logic [IDX_W-1:0]   cam_addrs,
    input  logic [ENTRIES-1:0] cam_mbits
);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_ALLOC  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MATCH,
        S_WRITE,
        S_FLUSH,
        S_RESP
    } state_t;

    state_t             state, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   rr_ptr, rr_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic [IDX_W-1:0]   flush_cnt, flush_d;
    logic [ENTRIES-1:0] valid_d;
    logic               hit_d, alloc_d, ack_d, we_d;
    logic [IDX_W-1:0]   hit_idx_d, alloc_idx_d, addrs_d;
    logic [TAG_W-1:0]   din_d;

    // Raw CAM hits are qualified by the valid bits so reset/stale FF tags never match
    logic [ENTRIES-1:0] qm;
    logic [IDX_W-1:0]   qm_idx, free_idx;
    logic               any_free;

    assign qm        = cam_mbits & valid;
    assign busy      = (state != S_IDLE);
    assign cam_argin = tag_q;
    assign cam_rd_n  = 1'b0;

    always_comb begin
        qm_idx   = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (qm[i]) begin
                qm_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state;
        tag_d       = tag_q;
        op_d        = op_q;
        rr_d        = rr_ptr;
        victim_d    = victim_q;
        flush_d     = flush_cnt;
        valid_d     = valid;
        hit_d       = hit;
        hit_idx_d   = hit_idx;
        alloc_d     = allocated;
        alloc_idx_d = alloc_idx;
        ack_d       = 1'b0;
        we_d        = 1'b0;
        din_d       = cam_din;
        addrs_d     = cam_addrs;
        case (state)
            S_IDLE: begin
                if (req) begin
                    tag_d   = tag;
                    op_d    = op;
                    alloc_d = 1'b0;
                    if (op == OP_FLUSH) begin
                        valid_d = '0;
                        hit_d   = 1'b0;
                        flush_d = '0;
                        we_d    = 1'b1;
                        addrs_d = '0;
                        din_d   = '1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_MATCH;
                    end
                end
            end
            S_MATCH: begin
                if (qm != '0) begin
                    hit_d     = 1'b1;
                    hit_idx_d = qm_idx;
                    if (op_q == OP_INVAL) begin
                        valid_d[qm_idx] = 1'b0;
                    end
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    hit_d = 1'b0;
                    if (op_q == OP_ALLOC) begin
                        // Round-robin pointer only moves when it actually picked the victim
                        if (any_free) begin
                            victim_d = free_idx;
                        end else begin
                            victim_d = rr_ptr;
                            rr_d     = rr_ptr + 1'b1;
                        end
                        we_d    = 1'b1;
                        addrs_d = victim_d;
                        din_d   = tag_q;
                        state_d = S_WRITE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WRITE: begin
                valid_d[victim_q] = 1'b1;
                alloc_d           = 1'b1;
                alloc_idx_d       = victim_q;
                ack_d             = 1'b1;
                state_d           = S_RESP;
            end
            S_FLUSH: begin
                if (flush_cnt == IDX_W'(ENTRIES - 1)) begin
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    flush_d = flush_cnt + 1'b1;
                    we_d    = 1'b1;
                    addrs_d = flush_cnt + 1'b1;
                    din_d   = '1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tag_q     <= '0;
            op_q      <= OP_LOOKUP;
            rr_ptr    <= '0;
            victim_q  <= '0;
            flush_cnt <= '0;
            valid     <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            allocated <= 1'b0;
            alloc_idx <= '0;
            ack       <= 1'b0;
            cam_we_n  <= 1'b0;
            cam_din   <= '0;
            cam_addrs <= '0;
        end else begin
            state     <= state_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            rr_ptr    <= rr_d;
            victim_q  <= victim_d;
            flush_cnt <= flush_d;
            valid     <= valid_d;
            hit       <= hit_d;
            hit_idx   <= hit_idx_d;
            allocated <= alloc_d;
            alloc_idx <= alloc_idx_d;
            ack       <= ack_d;
            cam_we_n  <= we_d;
            cam_din   <= din_d;
            cam_addrs <= addrs_d;
        end
    end

endmodule

// File: tb/tb_cam_tag_ctrl.sv
// tb/tb_cam_tag_ctrl.sv - self-checking bench for cam_tag_ctrl with a behavioural CAM and tag-table model
module tb_cam_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [7:0] tag;
    logic       busy, ack, hit, allocated;
    logic [1:0] hit_idx, alloc_idx, cam_addrs;
    logic [3:0] valid, cam_mbits;
    logic       cam_we_n, cam_rd_n;
    logic [7:0] cam_din, cam_argin;

    cam_tag_ctrl #(.TAG_W(8), .ENTRIES(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .tag(tag),
        .busy(busy), .ack(ack), .hit(hit), .hit_idx(hit_idx),
        .allocated(allocated), .alloc_idx(alloc_idx), .valid(valid),
        .cam_we_n(cam_we_n), .cam_rd_n(cam_rd_n), .cam_din(cam_din),
        .cam_argin(cam_argin), .cam_addrs(cam_addrs), .cam_mbits(cam_mbits)
    );

    always #5 clk = ~clk;

    // CAM tag store: powers up all ones, is never cleared by rst
    logic [7:0] cam_mem [4];
    logic       cam_ready;
    always @(posedge clk) begin
        if (!cam_ready) begin
            for (int i = 0; i < 4; i++) cam_mem[i] <= 8'hFF;
        end else if (cam_we_n) begin
            cam_mem[cam_addrs] <= cam_din;
        end
    end
    always_comb begin
        cam_mbits = '0;
        for (int i = 0; i < 4; i++) cam_mbits[i] = (cam_mem[i] == cam_argin);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: which tags are resident, in which slot, plus the round-robin pointer
    bit       m_valid [4];
    bit [7:0] m_tag   [4];
    int       m_rr;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_rr = 0;
    endtask

    task automatic model_apply(input logic [1:0] o, input logic [7:0] t,
                               output int e_hit, output int e_hidx, output int e_alloc,
                               output int e_aidx, output int e_lat, output int e_valid);
        int v;
        e_hit = 0; e_hidx = 0; e_alloc = 0; e_aidx = 0;
        if (o == 2'b11) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            e_lat = 5;
        end else begin
            for (int i = 0; i < 4; i++)
                if (e_hit == 0 && m_valid[i] && m_tag[i] == t) begin
                    e_hit = 1; e_hidx = i;
                end
            if (e_hit == 1) begin
                if (o == 2'b10) m_valid[e_hidx] = 0;
                e_lat = 2;
            end else if (o == 2'b01) begin
                v = -1;
                for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[i]) v = i;
                if (v < 0) begin
                    v = m_rr;
                    m_rr = (m_rr + 1) % 4;
                end
                m_tag[v] = t; m_valid[v] = 1;
                e_alloc = 1; e_aidx = v; e_lat = 3;
            end else begin
                e_lat = 2;
            end
        end
        e_valid = 0;
        for (int i = 0; i < 4; i++) if (m_valid[i]) e_valid += (1 << i);
    endtask

    // Issue one request; stray req/tag/op while busy must be ignored. Returns at the ack cycle.
    task automatic do_req(input logic [1:0] o, input logic [7:0] t, output int lat);
        req = 1'b1; op = o; tag = t;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) begin
                chk("busy_after_accept", int'(busy), 1);
                req = 1'b1; tag = 8'($urandom); op = 2'($urandom);
            end else begin
                req = 1'b0;
            end
            if (ack) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        chk("ack_one_cycle", int'(ack), 0);
        chk("idle_after_ack", int'(busy), 0);
    endtask

    task automatic check_result(input string nm, input int lat, input int e_hit, input int e_hidx,
                                input int e_alloc, input int e_aidx, input int e_lat, input int e_valid);
        chk({nm, "_latency"}, lat, e_lat);
        chk({nm, "_hit"}, int'(hit), e_hit);
        if (e_hit != 0) chk({nm, "_hit_idx"}, int'(hit_idx), e_hidx);
        chk({nm, "_allocated"}, int'(allocated), e_alloc);
        if (e_alloc != 0) chk({nm, "_alloc_idx"}, int'(alloc_idx), e_aidx);
        chk({nm, "_valid"}, int'(valid), e_valid);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] tag;
        int hit, hidx, alloc, aidx, vld, lat;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [1:0] o, input logic [7:0] t, input int h, input int hi,
                       input int a, input int ai, input int v, input int l);
        vec_t e;
        e.op = o; e.tag = t; e.hit = h; e.hidx = hi; e.alloc = a; e.aidx = ai; e.vld = v; e.lat = l;
        tbl.push_back(e);
    endtask

    initial begin
        int lat, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid, acks;
        logic [1:0] ro;
        int r;

        //  op     tag    hit hidx alloc aidx valid    lat
        add(2'b00, 8'hFF, 0, 0, 0, 0, 4'b0000, 2);
        add(2'b01, 8'h3C, 0, 0, 1, 0, 4'b0001, 3);
        add(2'b01, 8'h5A, 0, 0, 1, 1, 4'b0011, 3);
        add(2'b00, 8'h5A, 1, 1, 0, 0, 4'b0011, 2);
        add(2'b11, 8'h00, 0, 0, 0, 0, 4'b0000, 5);
        add(2'b01, 8'h10, 0, 0, 1, 0, 4'b0001, 3);
        add(2'b01, 8'h11, 0, 0, 1, 1, 4'b0011, 3);
        add(2'b01, 8'h12, 0, 0, 1, 2, 4'b0111, 3);
        add(2'b01, 8'h13, 0, 0, 1, 3, 4'b1111, 3);
        add(2'b01, 8'h20, 0, 0, 1, 0, 4'b1111, 3);
        add(2'b01, 8'h21, 0, 0, 1, 1, 4'b1111, 3);
        add(2'b00, 8'h10, 0, 0, 0, 0, 4'b1111, 2);
        add(2'b11, 8'h00, 0, 0, 0, 0, 4'b0000, 5);
        add(2'b01, 8'h10, 0, 0, 1, 0, 4'b0001, 3);
        add(2'b01, 8'h11, 0, 0, 1, 1, 4'b0011, 3);
        add(2'b01, 8'h12, 0, 0, 1, 2, 4'b0111, 3);
        add(2'b01, 8'h13, 0, 0, 1, 3, 4'b1111, 3);
        add(2'b10, 8'h11, 1, 1, 0, 0, 4'b1101, 2);
        add(2'b01, 8'h99, 0, 0, 1, 1, 4'b1111, 3);
        add(2'b10, 8'h77, 0, 0, 0, 0, 4'b1111, 2);
        add(2'b01, 8'h10, 1, 0, 0, 0, 4'b1111, 2);

        rst = 1'b1; req = 1'b0; op = 2'b00; tag = 8'h00; cam_ready = 1'b0;
        repeat (2) @(posedge clk);
        cam_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_allocated", int'(allocated), 0);
        chk("rst_cam_we", int'(cam_we_n), 0);
        chk("rst_cam_din", int'(cam_din), 0);
        chk("cam_rd_tied", int'(cam_rd_n), 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            do_req(tbl[k].op, tbl[k].tag, lat);
            model_apply(tbl[k].op, tbl[k].tag, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
            check_result($sformatf("vec%0d", k), lat, tbl[k].hit, tbl[k].hidx,
                         tbl[k].alloc, tbl[k].aidx, tbl[k].lat, tbl[k].vld);
            idle_check();
        end

        // Flush bus sequence: four consecutive writes of FF to addresses 0..3
        req = 1'b1; op = 2'b11; tag = 8'h42;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_we", int'(cam_we_n), 1);
            chk("flush_addr", int'(cam_addrs), i);
            chk("flush_din", int'(cam_din), 8'hFF);
            chk("flush_no_early_ack", int'(ack), 0);
            @(posedge clk); #1;
        end
        chk("flush_ack", int'(ack), 1);
        chk("flush_we_off", int'(cam_we_n), 0);
        chk("flush_valid", int'(valid), 0);
        chk("flush_hit", int'(hit), 0);
        chk("flush_alloc", int'(allocated), 0);
        model_apply(2'b11, 8'h42, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
        idle_check();

        // Reset landing in the WRITE cycle of an allocate-miss
        do_req(2'b01, 8'h3C, lat);
        model_apply(2'b01, 8'h3C, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
        check_result("pre_rst_alloc", lat, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
        idle_check();
        req = 1'b1; op = 2'b01; tag = 8'hA5;
        @(posedge clk); #1;
        req = 1'b0;
        chk("match_cycle_we", int'(cam_we_n), 0);
        chk("match_argin", int'(cam_argin), 8'hA5);
        @(posedge clk); #1;
        chk("write_cycle_we", int'(cam_we_n), 1);
        chk("write_cycle_addr", int'(cam_addrs), 1);
        chk("write_cycle_din", int'(cam_din), 8'hA5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_we", int'(cam_we_n), 0);
        chk("rst_mid_valid", int'(valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_alloc", int'(allocated), 0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack) acks++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_ack", acks, 0);
        model_reset();
        do_req(2'b00, 8'hA5, lat);
        model_apply(2'b00, 8'hA5, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
        check_result("post_rst_lookup", lat, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
        idle_check();

        // Randomized traffic over a small tag pool so hits, evictions and wraps all occur
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      ro = 2'b11;
            else if (r < 6)  ro = 2'b10;
            else if (r < 13) ro = 2'b01;
            else             ro = 2'b00;
            tag = 8'h40 + 8'($urandom_range(0, 6));
            do_req(ro, tag, lat);
            model_apply(ro, dut.tag_q, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
            check_result($sformatf("rnd%0d", n), lat, e_hit, e_hidx, e_alloc, e_aidx, e_lat, e_valid);
            idle_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
